// File: rtl/ccg_bist_pkg.sv
// Shared types and polynomial helpers for the CCG BIST harness.
// Helpers work on 64-bit containers with an explicit width so any parameterisation can reuse them.
package ccg_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [63:0] DEF_LFSR_POLY = 64'h0000_0000_0000_1C80;
    localparam logic [63:0] DEF_MISR_POLY = 64'h0000_0000_04C1_1DB7;

    function automatic logic [63:0] width_mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Galois step: shift left, fold the polynomial in when the outgoing MSB was set.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic [63:0] poly,
                                              input int unsigned w);
        logic [63:0] m;
        logic [63:0] r;
        logic        msb;
        m   = width_mask(w);
        msb = |(s & (64'd1 << (w - 1)));
        r   = (s << 1) & m;
        if (msb) r = r ^ (poly & m);
        return r;
    endfunction

    function automatic logic [63:0] misr_next(input logic [63:0] sig, input logic [63:0] data,
                                              input logic [63:0] poly, input int unsigned w);
        return lfsr_next(sig, poly, w) ^ (data & width_mask(w));
    endfunction

endpackage

// File: rtl/ccg_bist_harness_misr.sv
// Multiple-input signature register: compacts one zero-extended response word per enabled cycle.
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int unsigned      SIG_W     = 32,
    parameter int unsigned      NO        = 22,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEF_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [NO-1:0]    data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr)
            sig_d = '0;
        else if (en)
            sig_d = SIG_W'(misr_next(64'(sig_q), 64'(data), 64'(MISR_POLY), SIG_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/ccg_bist_harness.sv
// LFSR-driven self-test harness for one CCG circuit; responses compacted by ccg_misr.
// Optional toggle coverage outputs when CCG_TOGGLE_COV_EN is defined.
module ccg_bist_harness
    import ccg_bist_pkg::*;
#(
    parameter int unsigned      NI        = 13,
    parameter int unsigned      NO        = 22,
    parameter int unsigned      SIG_W     = 32,
    parameter logic [NI-1:0]    LFSR_POLY = NI'(DEF_LFSR_POLY),
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEF_MISR_POLY),
    parameter int unsigned      DUT_LAT   = 1,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NI-1:0]    seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [NI-1:0]    dut_in,
    input  logic [NO-1:0]    dut_out,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_cnt
`ifdef CCG_TOGGLE_COV_EN
    ,
    output logic [NO-1:0]    toggled_0,
    output logic [NO-1:0]    toggled_1,
    output logic             all_toggled
`endif
);

    localparam int unsigned PW = DUT_LAT + 1;

    state_e           state_q, state_d;
    logic [NI-1:0]    lfsr_q, lfsr_d;
    logic [NI-1:0]    dut_in_q, dut_in_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [PW-1:0]    vld_q, vld_d;
    logic [3:0]       drain_q, drain_d;
    logic             load;
    logic             issue;
    logic             sample;

    assign sample = vld_q[DUT_LAT];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        dut_in_d  = dut_in_q;
        num_vec_d = num_vec_q;
        issued_d  = issued_q;
        vec_cnt_d = vec_cnt_q;
        drain_d   = '0;
        load      = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // Seed goes straight into the LFSR at acceptance; nothing reads it before RUN.
                if (start) begin
                    state_d   = LOAD;
                    lfsr_d    = (seed == '0) ? NI'(1) : seed;
                    num_vec_d = num_vec;
                end
            end
            LOAD: begin
                load     = 1'b1;
                issued_d = '0;
                state_d  = (num_vec_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                issue    = 1'b1;
                dut_in_d = lfsr_q;
                lfsr_d   = NI'(lfsr_next(64'(lfsr_q), 64'(LFSR_POLY), NI));
                issued_d = issued_q + CNT_W'(1);
                if (issued_q + CNT_W'(1) == num_vec_q) state_d = DRAIN;
            end
            DRAIN: begin
                // DRAIN always spans DUT_LAT+1 cycles: exactly when the last valid leaves the pipe,
                // and it keeps the empty-run timing identical to a run with vectors.
                drain_d = drain_q + 4'd1;
                if (drain_q == 4'(DUT_LAT)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (load)
            vec_cnt_d = '0;
        else if (sample && (vec_cnt_q != '1))
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
        vld_d = load ? '0 : ((vld_q << 1) | PW'(issue));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            dut_in_q  <= '0;
            num_vec_q <= '0;
            issued_q  <= '0;
            vec_cnt_q <= '0;
            vld_q     <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            dut_in_q  <= dut_in_d;
            num_vec_q <= num_vec_d;
            issued_q  <= issued_d;
            vec_cnt_q <= vec_cnt_d;
            vld_q     <= vld_d;
            drain_q   <= drain_d;
        end
    end

    ccg_misr #(
        .SIG_W     (SIG_W),
        .NO        (NO),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .en   (sample),
        .clr  (load),
        .data (dut_out),
        .sig  (signature)
    );

    assign dut_in  = dut_in_q;
    assign vec_cnt = vec_cnt_q;
    assign busy    = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

`ifdef CCG_TOGGLE_COV_EN
    logic [NO-1:0] tog0_q, tog1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog0_q <= '0;
            tog1_q <= '0;
        end else if (load) begin
            tog0_q <= '0;
            tog1_q <= '0;
        end else if (sample) begin
            tog0_q <= tog0_q | ~dut_out;
            tog1_q <= tog1_q | dut_out;
        end
    end

    assign toggled_0   = tog0_q;
    assign toggled_1   = tog1_q;
    assign all_toggled = &(tog0_q & tog1_q);
`endif

endmodule

// File: tb/tb_ccg_bist_harness.sv
// Scoreboard bench: two harness instances (latency 1 / 22-bit netlist, latency 0 / 1-bit passthrough).
module tb_ccg_bist_harness;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] cnt;
        logic [21:0] t0;
        logic [21:0] t1;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference circuit driven by instance A (registered, so one cycle of latency).
    function automatic logic [21:0] f_a(input logic [12:0] x);
        return {x[12:4] & x[8:0], x ^ {x[0], x[12:1]}};
    endfunction

    logic        start_a, start_b;
    logic [12:0] seed_a, seed_b;
    logic [15:0] nv_a, nv_b;
    logic [12:0] din_a, din_b, dq_a;
    logic [21:0] dout_a;
    logic [0:0]  dout_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] sig_a, sig_b;
    logic [15:0] cnt_a, cnt_b;
`ifdef CCG_TOGGLE_COV_EN
    logic [21:0] tg0_a, tg1_a;
    logic [0:0]  tg0_b, tg1_b;
    logic        all_a, all_b;
`endif

    always @(posedge clk) dq_a <= din_a;
    assign dout_a = f_a(dq_a);
    assign dout_b = din_b[0];

    ccg_bist_harness #(.NI(13), .NO(22), .SIG_W(32), .DUT_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .num_vec(nv_a),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .signature(sig_a), .vec_cnt(cnt_a)
`ifdef CCG_TOGGLE_COV_EN
        , .toggled_0(tg0_a), .toggled_1(tg1_a), .all_toggled(all_a)
`endif
    );

    ccg_bist_harness #(.NI(13), .NO(1), .SIG_W(32), .DUT_LAT(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .num_vec(nv_b),
        .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .signature(sig_b), .vec_cnt(cnt_b)
`ifdef CCG_TOGGLE_COV_EN
        , .toggled_0(tg0_b), .toggled_1(tg1_b), .all_toggled(all_b)
`endif
    );

    // Behavioural reference: generate the vector sequence, run the responses through the MISR.
    function automatic exp_t model(input int k, input logic [12:0] s, input int n);
        exp_t        e;
        int unsigned v;
        int unsigned sg;
        logic [21:0] r;
        logic [21:0] msk;
        msk  = (k == 0) ? 22'h3FFFFF : 22'h000001;
        v    = (s == 13'd0) ? 32'd1 : 32'(s);
        sg   = 0;
        e.t0 = '0;
        e.t1 = '0;
        for (int i = 0; i < n; i++) begin
            r    = (k == 0) ? f_a(13'(v)) : 22'(v & 32'd1);
            sg   = (sg << 1) ^ (((sg >> 31) != 0) ? 32'h04C11DB7 : 32'h0) ^ 32'(r);
            e.t1 = e.t1 | r;
            e.t0 = e.t0 | (~r & msk);
            v    = ((v << 1) & 32'h1FFF) ^ ((((v >> 12) & 32'd1) != 0) ? 32'h1C80 : 32'h0);
        end
        e.sig   = sg;
        e.cnt   = 16'(n);
        e.lat   = n + ((k == 0) ? 1 : 0) + 2;
        e.start = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last;
    logic pd_a = 1'b0;
    logic pd_b = 1'b0;

    // Monitor: every rising done pops the oldest expectation for that instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pd_a = 1'b0;
            pd_b = 1'b0;
        end else begin
            if (done_a && !pd_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_a: done rose with no run outstanding");
                end else begin
                    e = q_a.pop_front();
                    chk("sig_a", 64'(sig_a), 64'(e.sig));
                    chk("cnt_a", 64'(cnt_a), 64'(e.cnt));
                    chk("lat_a", 64'(cyc - e.start), 64'(e.lat));
`ifdef CCG_TOGGLE_COV_EN
                    chk("tog0_a", 64'(tg0_a), 64'(e.t0));
                    chk("tog1_a", 64'(tg1_a), 64'(e.t1));
                    chk("all_a", 64'(all_a), 64'(&(e.t0 & e.t1)));
`endif
                end
            end
            if (done_b && !pd_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_b: done rose with no run outstanding");
                end else begin
                    e = q_b.pop_front();
                    chk("sig_b", 64'(sig_b), 64'(e.sig));
                    chk("cnt_b", 64'(cnt_b), 64'(e.cnt));
                    chk("lat_b", 64'(cyc - e.start), 64'(e.lat));
`ifdef CCG_TOGGLE_COV_EN
                    chk("tog0_b", 64'(tg0_b), 64'(e.t0[0]));
                    chk("tog1_b", 64'(tg1_b), 64'(e.t1[0]));
`endif
                end
            end
            pd_a = done_a;
            pd_b = done_b;
        end
    end

    task automatic start_run(input int k, input logic [12:0] s, input int n);
        exp_t e;
        @(negedge clk);
        if (k == 0) begin start_a = 1'b1; seed_a = s; nv_a = 16'(n); end
        else        begin start_b = 1'b1; seed_b = s; nv_b = 16'(n); end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        e       = model(k, s, n);
        e.start = cyc;
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
        last = e;
        if (n > 0) begin
            // LOAD edge, then the first RUN edge presents the (zero-fixed) seed.
            @(negedge clk);
            @(negedge clk);
            chk("first_vec", 64'((k == 0) ? din_a : din_b), 64'((s == 13'd0) ? 13'd1 : s));
        end
    endtask

    task automatic wait_done(input int k, input int bound);
        logic d;
        d = 1'b0;
        for (int i = 0; i < bound; i++) begin
            d = (k == 0) ? done_a : done_b;
            if (d) break;
            @(negedge clk);
        end
        if (!d) begin
            checks++; errors++;
            $display("FAIL timeout_%0d: done still 0 after %0d cycles, required 1", k, bound);
            if (k == 0) q_a.delete(); else q_b.delete();
        end else begin
            repeat (3) @(negedge clk);
            chk("sig_hold", 64'((k == 0) ? sig_a : sig_b), 64'(last.sig));
            chk("done_hold", 64'((k == 0) ? done_a : done_b), 64'd1);
        end
    endtask

    initial begin
        logic [12:0] s;
        int          n;
        rst = 1'b1;
        start_a = 1'b0; seed_a = '0; nv_a = '0;
        start_b = 1'b0; seed_b = '0; nv_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_din", 64'(din_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_sig", 64'(sig_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        rst = 1'b0;

        start_run(0, 13'd1, 0);   wait_done(0, 20);
        start_run(0, 13'd0, 7);   wait_done(0, 40);
        start_run(0, 13'd5, 1);   wait_done(0, 40);
        for (int i = 0; i < 6; i++) begin
            s = 13'($urandom);
            n = int'($urandom_range(1, 60));
            start_run(0, s, n);
            wait_done(0, n + 40);
        end

        // Start while busy must be ignored; the monitor's latency check catches a restart.
        s = 13'($urandom);
        start_run(0, s, 100);
        repeat (20) @(negedge clk);
        chk("busy_mid", 64'(busy_a), 64'd1);
        start_a = 1'b1; seed_a = ~s; nv_a = 16'd5;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 200);

        // Asynchronous reset mid-run, then a clean rerun of the same vectors.
        s = 13'($urandom);
        start_run(0, s, 100);
        for (int i = 0; i < 200; i++) begin
            if (cnt_a == 16'd50) break;
            @(negedge clk);
        end
        chk("cnt_at_abort", 64'(cnt_a), 64'd50);
        #2 rst = 1'b1;
        #1;
        chk("arst_din", 64'(din_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_sig", 64'(sig_a), 64'd0);
        chk("arst_cnt", 64'(cnt_a), 64'd0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        start_run(0, s, 100);
        wait_done(0, 200);

        // Latency-0 passthrough instance.
        start_run(1, 13'd1, 4);   wait_done(1, 30);
        start_run(1, 13'd9, 0);   wait_done(1, 30);
        for (int i = 0; i < 3; i++) begin
            s = 13'($urandom);
            n = int'($urandom_range(1, 40));
            start_run(1, s, n);
            wait_done(1, n + 30);
        end

        repeat (2) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover: %0d/%0d runs never completed, required 0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
